// File: rtl/trap_controller_if.sv
// Bus between the trap controller, the pipeline flags and the machine-mode CSR block.
// master: the trap controller. slave: the pipeline / CSR side that drives flags and consumes pulses.
interface trap_controller_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic        ex_instr_misaligned;
  logic        ex_illegal;
  logic        ex_ebreak;
  logic        ex_load_misaligned;
  logic        ex_store_misaligned;
  logic        ex_ecall;
  logic        is_mret;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_tmr;
  logic        mstatus_mie;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        cause_set;
  logic [3:0]  cause_in;
  logic        I_or_E_in;
  logic        mepc_set;
  logic [29:0] exception_intr_address_in;
  logic        mie_clear;
  logic        mie_set;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  modport master (
    input  instr_valid, pc, ex_instr_misaligned, ex_illegal, ex_ebreak,
           ex_load_misaligned, ex_store_misaligned, ex_ecall, is_mret,
           irq_ext, irq_sw, irq_tmr, mstatus_mie, mtvec_in, mepc_in,
    output cause_set, cause_in, I_or_E_in, mepc_set, exception_intr_address_in,
           mie_clear, mie_set, pc_redirect, redirect_pc, flush, busy
  );

  modport slave (
    output instr_valid, pc, ex_instr_misaligned, ex_illegal, ex_ebreak,
           ex_load_misaligned, ex_store_misaligned, ex_ecall, is_mret,
           irq_ext, irq_sw, irq_tmr, mstatus_mie, mtvec_in, mepc_in,
    input  cause_set, cause_in, I_or_E_in, mepc_set, exception_intr_address_in,
           mie_clear, mie_set, pc_redirect, redirect_pc, flush, busy
  );
endinterface

// File: rtl/trap_controller.sv
// Trap sequencer: picks the winning exception/interrupt at commit, pulses the
// machine-mode CSR trap-entry inputs, then redirects fetch to MTVEC (or to MEPC on mret).
module trap_controller #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [3:0]  EXT_IRQ_CAUSE = 4'd11,
  parameter logic [3:0]  SW_IRQ_CAUSE  = 4'd3,
  parameter logic [3:0]  TMR_IRQ_CAUSE = 4'd7
) (
  input  logic               clk,
  input  logic               reset,
  trap_controller_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAP_CSR  = 2'd1,
    TRAP_JUMP = 2'd2,
    MRET_JUMP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_cause_set;
  logic [3:0]  r_cause_in;
  logic        r_i_or_e;
  logic        r_mepc_set;
  logic [29:0] r_epc;
  logic        r_mie_clear;
  logic        r_mie_set;
  logic        r_pc_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_flush;
  logic        r_busy;

  logic        w_exc;
  logic [3:0]  w_exc_code;
  logic        w_irq;
  logic [3:0]  w_irq_code;
  logic        w_unused_bits;

  // Targets and the trapped PC are word aligned; the low bits are intentionally dropped.
  assign w_unused_bits = ^{bus.pc[1:0], bus.mtvec_in[1:0], bus.mepc_in[1:0]};

  // Exception and interrupt priority encoders for the committing instruction.
  always_comb begin
    w_exc      = bus.ex_instr_misaligned | bus.ex_illegal | bus.ex_ebreak |
                 bus.ex_ecall | bus.ex_load_misaligned | bus.ex_store_misaligned;
    w_exc_code = 4'd0;
    if (bus.ex_instr_misaligned)      w_exc_code = 4'd0;
    else if (bus.ex_illegal)          w_exc_code = 4'd2;
    else if (bus.ex_ebreak)           w_exc_code = 4'd3;
    else if (bus.ex_ecall)            w_exc_code = 4'd11;
    else if (bus.ex_load_misaligned)  w_exc_code = 4'd4;
    else if (bus.ex_store_misaligned) w_exc_code = 4'd6;

    w_irq      = bus.mstatus_mie & (bus.irq_ext | bus.irq_sw | bus.irq_tmr);
    w_irq_code = TMR_IRQ_CAUSE;
    if (bus.irq_ext)     w_irq_code = EXT_IRQ_CAUSE;
    else if (bus.irq_sw) w_irq_code = SW_IRQ_CAUSE;
  end

  // Sequencer FSM; every output is a register so pulses last one full cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cause_set   <= 1'b0;
      r_cause_in    <= 4'd0;
      r_i_or_e      <= 1'b0;
      r_mepc_set    <= 1'b0;
      r_epc         <= 30'd0;
      r_mie_clear   <= 1'b0;
      r_mie_set     <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_redirect_pc <= RESET_PC;
      r_flush       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cause_set   <= 1'b0;
      r_mepc_set    <= 1'b0;
      r_mie_clear   <= 1'b0;
      r_mie_set     <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_flush       <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (bus.instr_valid) begin
            if (w_exc || w_irq) begin
              // The trapped instruction is not executed; MEPC gets its own PC.
              r_state     <= TRAP_CSR;
              r_cause_in  <= w_exc ? w_exc_code : w_irq_code;
              r_i_or_e    <= ~w_exc;
              r_epc       <= bus.pc[31:2];
              r_cause_set <= 1'b1;
              r_mepc_set  <= 1'b1;
              r_mie_clear <= 1'b1;
              r_flush     <= 1'b1;
              r_busy      <= 1'b1;
            end else if (bus.is_mret) begin
              r_state       <= MRET_JUMP;
              r_mie_set     <= 1'b1;
              r_flush       <= 1'b1;
              r_pc_redirect <= 1'b1;
              r_redirect_pc <= {bus.mepc_in[31:2], 2'b00};
              r_busy        <= 1'b1;
            end
          end
        end
        TRAP_CSR: begin
          // MTVEC is sampled here so a CSR write that just landed is honoured.
          r_state       <= TRAP_JUMP;
          r_pc_redirect <= 1'b1;
          r_redirect_pc <= {bus.mtvec_in[31:2], 2'b00};
          r_busy        <= 1'b1;
        end
        TRAP_JUMP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        MRET_JUMP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cause_set                 = r_cause_set;
  assign bus.cause_in                  = r_cause_in;
  assign bus.I_or_E_in                 = r_i_or_e;
  assign bus.mepc_set                  = r_mepc_set;
  assign bus.exception_intr_address_in = r_epc;
  assign bus.mie_clear                 = r_mie_clear;
  assign bus.mie_set                   = r_mie_set;
  assign bus.pc_redirect               = r_pc_redirect;
  assign bus.redirect_pc               = r_redirect_pc;
  assign bus.flush                     = r_flush;
  assign bus.busy                      = r_busy;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus pushes expected output beats,
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_trap_controller;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  trap_controller_if ifc();

  trap_controller #(
    .RESET_PC     (32'h0000_0000),
    .EXT_IRQ_CAUSE(4'd11),
    .SW_IRQ_CAUSE (4'd3),
    .TMR_IRQ_CAUSE(4'd7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse vector order: cause_set, mepc_set, mie_clear, mie_set, pc_redirect, flush, busy
  typedef struct {
    int          cyc;
    logic [6:0]  p;
    logic [3:0]  cause;
    logic        ie;
    logic [29:0] addr;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] act_p();
    return {ifc.cause_set, ifc.mepc_set, ifc.mie_clear, ifc.mie_set,
            ifc.pc_redirect, ifc.flush, ifc.busy};
  endfunction

  // Monitor: any pulse on the bus must match the oldest expected beat.
  always @(negedge clk) begin
    logic [6:0] a;
    exp_t e;
    logic ok;
    a = act_p();
    if (|a[6:1]) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat cyc=%0d got pulses=%b cause=%0d", cyc, a, ifc.cause_in);
      end else begin
        e  = q.pop_front();
        ok = (a == e.p) && (cyc == e.cyc);
        if (e.p[6]) ok = ok && (ifc.cause_in == e.cause) && (ifc.I_or_E_in == e.ie) &&
                         (ifc.exception_intr_address_in == e.addr);
        if (e.p[2]) ok = ok && (ifc.redirect_pc == e.rpc);
        if (!ok) begin
          fails++;
          $display("FAIL beat cyc=%0d/%0d got p=%b cause=%0d ie=%b addr=%h rpc=%h want p=%b cause=%0d ie=%b addr=%h rpc=%h",
                   cyc, e.cyc, a, ifc.cause_in, ifc.I_or_E_in, ifc.exception_intr_address_in,
                   ifc.redirect_pc, e.p, e.cause, e.ie, e.addr, e.rpc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_trap(input int n, input logic [3:0] c, input logic ie,
                           input logic [31:0] pcv, input logic [31:0] mtv);
    exp_t e;
    e.cyc = n + 1; e.p = 7'b1110011; e.cause = c; e.ie = ie; e.addr = pcv[31:2]; e.rpc = 32'd0;
    q.push_back(e);
    e.cyc = n + 2; e.p = 7'b0000101; e.rpc = {mtv[31:2], 2'b00};
    q.push_back(e);
  endtask

  task automatic push_mret(input int n, input logic [31:0] mepcv);
    exp_t e;
    e.cyc = n + 1; e.p = 7'b0001111; e.cause = 4'd0; e.ie = 1'b0; e.addr = 30'd0;
    e.rpc = {mepcv[31:2], 2'b00};
    q.push_back(e);
  endtask

  task automatic clear_inputs();
    ifc.instr_valid = 1'b0;
    ifc.ex_instr_misaligned = 1'b0; ifc.ex_illegal = 1'b0; ifc.ex_ebreak = 1'b0;
    ifc.ex_load_misaligned = 1'b0; ifc.ex_store_misaligned = 1'b0; ifc.ex_ecall = 1'b0;
    ifc.is_mret = 1'b0; ifc.irq_ext = 1'b0; ifc.irq_sw = 1'b0; ifc.irq_tmr = 1'b0;
    ifc.mstatus_mie = 1'b0;
  endtask

  // ex: {ecall, store, load, ebreak, illegal, instr_mis}; irq: {tmr, sw, ext}
  // kind: 0 no action, 1 trap, 2 mret. Called at posedge+1.
  task automatic run_vec(input logic [5:0] ex, input logic [2:0] irq, input logic mie,
                         input logic mret, input logic [31:0] pcv, input logic [31:0] mtv,
                         input logic [31:0] mepcv, input int kind, input logic [3:0] ec,
                         input logic eie, input int hold);
    int n;
    ifc.instr_valid = 1'b1; ifc.pc = pcv; ifc.mtvec_in = mtv; ifc.mepc_in = mepcv;
    ifc.ex_instr_misaligned = ex[0]; ifc.ex_illegal = ex[1]; ifc.ex_ebreak = ex[2];
    ifc.ex_load_misaligned = ex[3]; ifc.ex_store_misaligned = ex[4]; ifc.ex_ecall = ex[5];
    ifc.irq_ext = irq[0]; ifc.irq_sw = irq[1]; ifc.irq_tmr = irq[2];
    ifc.mstatus_mie = mie; ifc.is_mret = mret;
    n = cyc;
    if (kind == 1) push_trap(n, ec, eie, pcv, mtv);
    if (kind == 2) push_mret(n, mepcv);
    @(posedge clk); #1;
    ifc.ex_instr_misaligned = 1'b0; ifc.ex_illegal = 1'b0; ifc.ex_ebreak = 1'b0;
    ifc.ex_load_misaligned = 1'b0; ifc.ex_store_misaligned = 1'b0; ifc.ex_ecall = 1'b0;
    ifc.is_mret = 1'b0;
    if (hold == 0) ifc.instr_valid = 1'b0;
    @(negedge clk);
    check("busy_after_detect", {31'd0, ifc.busy}, {31'd0, (kind != 0)});
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      clear_inputs();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_back_idle", {31'd0, ifc.busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    tests = 0; fails = 0; cyc = 0;
    reset = 1'b1;
    clear_inputs();
    ifc.pc = 32'h0000_0104; ifc.mtvec_in = 32'h0000_0200; ifc.mepc_in = 32'h0;
    ifc.instr_valid = 1'b1; ifc.ex_illegal = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pulses", {25'd0, act_p()}, 32'd0);
    check("rst_redirect_pc", ifc.redirect_pc, 32'h0000_0000);
    check("rst_cause_in", {28'd0, ifc.cause_in}, 32'd0);
    check("rst_epc", {2'd0, ifc.exception_intr_address_in}, 32'd0);
    check("rst_ie", {31'd0, ifc.I_or_E_in}, 32'd0);

    // Illegal held through reset: taken on the first edge after release.
    @(posedge clk); #1;
    n = cyc;
    push_trap(n, 4'd2, 1'b0, 32'h0000_0104, 32'h0000_0200);
    reset = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    repeat (4) @(posedge clk); #1;

    //       ex          irq     mie  mret pc            mtvec         mepc          kind cause ie hold
    run_vec(6'b101000, 3'b001, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0200, 32'h0,        1, 4'd11, 1'b0, 2);
    run_vec(6'b000000, 3'b110, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0200, 32'h0,        1, 4'd3,  1'b1, 0);
    run_vec(6'b000000, 3'b110, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0200, 32'h0,        0, 4'd0,  1'b0, 0);
    run_vec(6'b000000, 3'b101, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0303, 32'h0,        1, 4'd11, 1'b1, 0);
    run_vec(6'b000000, 3'b100, 1'b1, 1'b0, 32'h0000_2004, 32'h0000_0400, 32'h0,        1, 4'd7,  1'b1, 0);
    run_vec(6'b000111, 3'b000, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0200, 32'h0,        1, 4'd0,  1'b0, 0);
    run_vec(6'b100100, 3'b000, 1'b0, 1'b0, 32'h0000_0014, 32'h0000_0200, 32'h0,        1, 4'd3,  1'b0, 0);
    run_vec(6'b011000, 3'b000, 1'b0, 1'b0, 32'h0000_0018, 32'h0000_0200, 32'h0,        1, 4'd4,  1'b0, 0);
    run_vec(6'b010000, 3'b001, 1'b1, 1'b1, 32'h0000_001C, 32'h0000_0500, 32'h0000_0108, 1, 4'd6, 1'b0, 0);
    run_vec(6'b000000, 3'b000, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0200, 32'h0000_0108, 2, 4'd0, 1'b0, 0);
    run_vec(6'b000000, 3'b001, 1'b0, 1'b1, 32'h0000_0024, 32'h0000_0200, 32'h0000_010B, 2, 4'd0, 1'b0, 0);

    // Pending irq with no committing instruction: nothing happens.
    ifc.irq_ext = 1'b1; ifc.mstatus_mie = 1'b1; ifc.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_valid_no_trap", {31'd0, ifc.busy}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();

    // Reset while in TRAP_CSR aborts the sequence.
    ifc.instr_valid = 1'b1; ifc.ex_illegal = 1'b1; ifc.pc = 32'h0000_0300;
    ifc.mtvec_in = 32'h0000_0600;
    n = cyc;
    begin
      exp_t e;
      e.cyc = n + 1; e.p = 7'b1110011; e.cause = 4'd2; e.ie = 1'b0;
      e.addr = 30'h0000_00C0; e.rpc = 32'd0;
      q.push_back(e);
    end
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pulses", {25'd0, act_p()}, 32'd0);
    check("abort_redirect_pc", ifc.redirect_pc, 32'h0000_0000);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_stays_idle", {31'd0, ifc.busy}, 32'd0);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
